// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory bus between instruction fetch and data access
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inst_req_i,
    input  logic [AW-1:0]   inst_addr_i,
    output logic [DW-1:0]   inst_rdata_o,
    output logic            inst_ok_o,
    input  logic            data_req_i,
    input  logic            data_we_i,
    input  logic [DW/8-1:0] data_be_i,
    input  logic [AW-1:0]   data_addr_i,
    input  logic [DW-1:0]   data_wdata_i,
    output logic [DW-1:0]   data_rdata_o,
    output logic            data_ok_o,
    output logic            bus_err_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [DW/8-1:0] mem_be_o,
    output logic [AW-1:0]   mem_addr_o,
    output logic [DW-1:0]   mem_wdata_o,
    input  logic [DW-1:0]   mem_rdata_i,
    input  logic            mem_ready_i,
    output logic            stall_o
);
    localparam int BW = DW / 8;
    localparam int CW = TIMEOUT < 2 ? 1 : $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;
    state_t        state_q, state_d;
    logic          last_d_q, last_d_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [BW-1:0] mem_be_q, mem_be_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] inst_rdata_q, inst_rdata_d, data_rdata_q, data_rdata_d;
    logic          inst_ok_q, inst_ok_d, data_ok_q, data_ok_d, bus_err_q, bus_err_d;
    logic          grant_data, wd_hit, owner_i;
    // DATA wins a tie unless it also won the previous grant (last_d_q=1 means DATA)
    assign grant_data = data_req_i & (~inst_req_i | ~last_d_q);
    // Fires on the TIMEOUT-th waiting cycle, so mem_req stays up exactly TIMEOUT cycles
    assign wd_hit     = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));
    assign owner_i    = state_q == BUSY_I;
    assign inst_rdata_o = inst_rdata_q;
    assign inst_ok_o    = inst_ok_q;
    assign data_rdata_o = data_rdata_q;
    assign data_ok_o    = data_ok_q;
    assign bus_err_o    = bus_err_q;
    assign mem_req_o    = mem_req_q;
    assign mem_we_o     = mem_we_q;
    assign mem_be_o     = mem_be_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign stall_o      = (inst_req_i & ~inst_ok_q) | (data_req_i & ~data_ok_q);
    // Next state: grant in IDLE, complete or abort in BUSY, one pulse cycle in DONE
    always_comb begin
        state_d      = state_q;
        last_d_d     = last_d_q;
        cnt_d        = cnt_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_be_d     = mem_be_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        inst_ok_d    = 1'b0;
        data_ok_d    = 1'b0;
        bus_err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (inst_req_i | data_req_i) begin
                    state_d     = grant_data ? BUSY_D : BUSY_I;
                    last_d_d    = grant_data;
                    cnt_d       = '0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = grant_data & data_we_i;
                    mem_be_d    = (grant_data & data_we_i) ? data_be_i : '1;
                    mem_addr_d  = grant_data ? data_addr_i : inst_addr_i;
                    mem_wdata_d = grant_data ? data_wdata_i : '0;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ready_i | wd_hit) begin
                    state_d      = DONE;
                    mem_req_d    = 1'b0;
                    inst_ok_d    = owner_i;
                    data_ok_d    = ~owner_i;
                    bus_err_d    = ~mem_ready_i;
                    inst_rdata_d = (mem_ready_i & owner_i) ? mem_rdata_i : inst_rdata_q;
                    data_rdata_d = (mem_ready_i & ~owner_i & ~mem_we_q) ? mem_rdata_i : data_rdata_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_d_q     <= 1'b0;
            cnt_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
            inst_ok_q    <= 1'b0;
            data_ok_q    <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_d_q     <= last_d_d;
            cnt_q        <= cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_be_q     <= mem_be_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
            inst_ok_q    <= inst_ok_d;
            data_ok_q    <= data_ok_d;
            bus_err_q    <= bus_err_d;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction-timeline model
module tb_mem_arbiter;
    localparam int AW = 32, DW = 32, BW = DW / 8, TO = 4;
    logic clk = 1'b0, rst = 1'b1;
    logic inst_req, data_req, data_we, mem_ready;
    logic [AW-1:0] inst_addr, data_addr;
    logic [BW-1:0] data_be;
    logic [DW-1:0] data_wdata, mem_rdata;
    logic [DW-1:0] inst_rdata_o, data_rdata_o, mem_wdata_o;
    logic inst_ok_o, data_ok_o, bus_err_o, mem_req_o, mem_we_o, stall_o;
    logic [BW-1:0] mem_be_o;
    logic [AW-1:0] mem_addr_o;
    int checks = 0, errors = 0;
    logic [DW-1:0] exp_irdata = '0, exp_drdata = '0;
    bit last_data = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .inst_req_i(inst_req), .inst_addr_i(inst_addr), .inst_rdata_o(inst_rdata_o), .inst_ok_o(inst_ok_o),
        .data_req_i(data_req), .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
        .data_wdata_i(data_wdata), .data_rdata_o(data_rdata_o), .data_ok_o(data_ok_o),
        .bus_err_o(bus_err_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata),
        .mem_ready_i(mem_ready), .stall_o(stall_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag, input logic exp_stall);
        chk({tag, "_mem_req"}, mem_req_o, 0);
        chk({tag, "_mem_we"}, mem_we_o, 0);
        chk({tag, "_mem_be"}, mem_be_o, 0);
        chk({tag, "_mem_addr"}, mem_addr_o, 0);
        chk({tag, "_mem_wdata"}, mem_wdata_o, 0);
        chk({tag, "_inst_ok"}, inst_ok_o, 0);
        chk({tag, "_data_ok"}, data_ok_o, 0);
        chk({tag, "_bus_err"}, bus_err_o, 0);
        chk({tag, "_inst_rdata"}, inst_rdata_o, 0);
        chk({tag, "_data_rdata"}, data_rdata_o, 0);
        chk({tag, "_stall"}, stall_o, exp_stall);
    endtask

    // One group of requests raised together while the arbiter is idle. The model lays the
    // transactions out on a timeline: grant at t, bus busy for min(delay+1, TO) cycles,
    // ok one cycle later, next grant the cycle after that. Called at posedge+1.
    task automatic run_group(input bit ir, input bit dr, input bit we, input logic [BW-1:0] be,
                             input logic [AW-1:0] ia, input logic [AW-1:0] da, input logic [DW-1:0] wd,
                             input int di, input int dd, input logic [DW-1:0] ri, input logic [DW-1:0] rd);
        bit own[2];
        bit er[2];
        int d[2], n[2], g[2], ok[2];
        logic [DW-1:0] rv[2];
        int ns, t, oki, okd;
        bit fd;
        fd = dr && !(ir && last_data);
        ns = 0;
        if (fd) begin own[ns] = 1; d[ns] = dd; rv[ns] = rd; ns++; end
        if (ir) begin own[ns] = 0; d[ns] = di; rv[ns] = ri; ns++; end
        if (dr && !fd) begin own[ns] = 1; d[ns] = dd; rv[ns] = rd; ns++; end
        t = 0; oki = -1; okd = -1;
        for (int k = 0; k < ns; k++) begin
            g[k] = t;
            n[k] = d[k] < TO ? d[k] + 1 : TO;
            er[k] = d[k] >= TO;
            ok[k] = t + n[k] + 1;
            t = ok[k] + 1;
            if (own[k]) okd = ok[k]; else oki = ok[k];
        end
        last_data = own[ns-1];
        for (int c = 0; c <= ok[ns-1]; c++) begin
            int k;
            bit rdy, eerr, eoi, eod;
            k = -1;
            for (int j = 0; j < ns; j++) if (c > g[j] && c <= g[j] + n[j]) k = j;
            inst_req = ir && c <= oki;
            data_req = dr && c <= okd;
            inst_addr = ia; data_addr = da; data_we = we; data_be = be; data_wdata = wd;
            rdy = (k >= 0) ? (c == g[k] + 1 + d[k]) : ($urandom_range(0, 3) == 0);
            mem_rdata = (k >= 0 && rdy) ? rv[k] : $urandom;
            mem_ready = rdy;
            #1;
            eoi = c == oki;
            eod = c == okd;
            eerr = 0;
            for (int j = 0; j < ns; j++) if (c == ok[j] && er[j]) eerr = 1;
            chk("mem_req", mem_req_o, k >= 0);
            chk("inst_ok", inst_ok_o, eoi);
            chk("data_ok", data_ok_o, eod);
            chk("bus_err", bus_err_o, eerr);
            chk("stall", stall_o, (inst_req & ~eoi) | (data_req & ~eod));
            chk("inst_rdata", inst_rdata_o, exp_irdata);
            chk("data_rdata", data_rdata_o, exp_drdata);
            if (k >= 0) begin
                chk("mem_addr", mem_addr_o, own[k] ? da : ia);
                chk("mem_we", mem_we_o, own[k] & we);
                chk("mem_be", mem_be_o, (own[k] && we) ? be : {BW{1'b1}});
                if (own[k] && we) chk("mem_wdata", mem_wdata_o, wd);
                if (rdy && !own[k]) exp_irdata = rv[k];
                if (rdy && own[k] && !we) exp_drdata = rv[k];
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        inst_req = 0; data_req = 0; data_we = 0; data_be = '0; inst_addr = '0; data_addr = '0;
        data_wdata = '0; mem_ready = 0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset", 1'b0);
        rst = 0;
        run_group(1, 0, 0, '0, 32'h0040_0000, '0, '0, 0, 0, 32'h2408_000A, '0);
        run_group(1, 1, 0, '0, 32'h0040_0004, 32'h1001_0004, '0, 0, 0, $urandom, $urandom);
        run_group(0, 1, 1, 4'b0011, '0, 32'h1001_0008, 32'hDEAD_BEEF, 0, 2, '0, $urandom);
        for (int i = 0; i < 4; i++)
            run_group(1, 1, 1'(i & 1), 4'b1100, 32'h0040_0100 + 32'(i * 4), 32'h1001_0100 + 32'(i * 4),
                      $urandom, i, 3 - i, $urandom, $urandom);
        run_group(0, 1, 0, '0, '0, 32'h1001_0200, '0, 0, TO + 2, '0, $urandom);
        run_group(1, 1, 0, '0, 32'h0040_0200, 32'h1001_0204, '0, 1, 0, $urandom, $urandom);
        run_group(0, 1, 0, '0, '0, 32'h1001_0208, '0, 0, TO - 1, '0, $urandom);
        run_group(1, 0, 0, '0, 32'h0040_0300, '0, '0, TO, 0, $urandom, '0);
        // reset during the second BUSY cycle of a load abandons it without an ok pulse
        inst_req = 0; data_req = 1; data_we = 0; data_addr = 32'h1001_0010; mem_ready = 0;
        @(posedge clk); #1;
        chk("rst_busy_req", mem_req_o, 1);
        @(posedge clk); #1;
        rst = 1;
        #1;
        chk("rst_busy2_stall", stall_o, 1);
        @(posedge clk); #1;
        chk_zero("rst_mid1", 1'b1);
        @(posedge clk); #1;
        chk_zero("rst_mid2", 1'b1);
        data_req = 0; rst = 0;
        #1;
        chk("rst_stall_drop", stall_o, 0);
        last_data = 0; exp_irdata = '0; exp_drdata = '0;
        run_group(1, 1, 0, '0, 32'h0040_0400, 32'h1001_0400, '0, 0, 1, $urandom, $urandom);
        for (int i = 0; i < 150; i++) begin
            bit ir, dr;
            ir = 1'($urandom_range(0, 1));
            dr = 1'($urandom_range(0, 1));
            if (!ir && !dr) dr = 1;
            run_group(ir, dr, 1'($urandom_range(0, 1)), BW'($urandom), $urandom, $urandom, $urandom,
                      int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), $urandom, $urandom);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
